fx2_stream_reader: RTL
======================

# fx2_stream_reader

Host-to-device counterpart of the FX2 streaming write path. Drains the FX2 EP2 OUT slave FIFO over the 16-bit GPIF bus and strips each packet's header word. Unpacks the 48-bit word triplets into 24-bit sample beats on a valid/ready stream toward the MyriadRF TX datapath. Instantiated next to the FX2 write master and shares the `fd` bus pins through top-level tristate logic driven by `sloe`.

## Interface
Parameters:
- `PKT_WORDS`, 256: 16-bit words per FX2 packet, header included. `PKT_WORDS-1` must be a multiple of 3.
- `HDR_WORD`, 16'hA55A: expected header value.
- `FIFO_DEPTH`, 4: output sample FIFO depth. Power of 2, minimum 4.

Ports:
- `clk` in 1: single clock. FX2 IFCLK domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `resync` in 1: synchronous realign pulse.
- `flag_a` in 1: EP2 empty flag, active-low (1 = data available).
- `fd_i` in 16: FX2 data bus input.
- `slrd` out 1: read strobe, active-low.
- `sloe` out 1: output enable, active-low.
- `fifoadr` out 2: FIFO address; constant 2'b00 (EP2).
- `m_data_o` out 24: sample.
- `m_valid_o` out 1: sample valid.
- `m_ready_i` in 1: sink ready.
- `hdr_err_o` out 1: one-cycle pulse on a header mismatch.

## Operation
- `flag_a` and `fd_i` are registered on input (`flag_q`, `fd_q`) before any use.
- `room` = FIFO free entries ≥ 2.
- FSM states:
  - IDLE: `sloe`=1, `slrd`=1. Go to OE when `flag_q`=1 and `room`=1.
  - OE: `sloe`=0. Go to RD unconditionally.
  - RD: `sloe`=0, `slrd`=0 for exactly one cycle. Go to GAP.
  - GAP: `sloe`=0, `slrd`=1, lasts 2 cycles. Then go to RD if `flag_q`=1 and `room`=1, else go to IDLE.
- Word capture: `fd_q` captured on the edge ending RD. It is processed the next cycle as `word_v`.
- Word counter `wcnt`, 0..PKT_WORDS-1, advances on each `word_v` and wraps to 0.
  - `wcnt`=0 is the header word and is never emitted.
  - `wcnt`=1..PKT_WORDS-1 are payload words.
- Payload phase `ph` (0,1,2) is cleared at every header word.
  - ph0: latch w0.
  - ph1: latch w1 and push sample {w1[7:0], w0}.
  - ph2: push sample {w2, w1[15:8]}.
- Header check (see Configuration): on a mismatch, pulse `hdr_err_o` and set `drop`. While `drop`=1, payload words are counted but not pushed. `drop` clears at the next header.
- FIFO: `m_valid_o` = FIFO not empty. A pop happens when `m_valid_o` & `m_ready_i`. Push and pop in the same cycle are allowed when full.
- `resync` (sync, priority below `rst_n`):
  - FSM to IDLE.
  - `wcnt`, `ph`, `drop` and the FIFO cleared.
  - A `word_v` in the same cycle is discarded.
  - The next word read is treated as a header.

## Timing
- Reset values:
  - `slrd`=1, `sloe`=1, `fifoadr`=2'b00.
  - `m_valid_o`=0, `m_data_o`=0, `hdr_err_o`=0.
  - FSM in IDLE; all counters 0.
- Sustained read rate: 1 word per 3 cycles (RD, GAP, GAP).
- Latency, RD edge to sample visible on `m_valid_o`: 2 cycles (`fd_q`, then FIFO write).
- `flag_q` going to 0 during GAP ends the burst. No read is issued on a stale flag, because GAP spans the 2-cycle flag latency.
- The `room` check guarantees no FIFO overflow. Pushes are never lost.
- An empty FIFO with `m_ready_i`=1 has no effect.

## Configuration
- `FX2_RD_HDR_CHECK_EN` defined: the header word is compared with `HDR_WORD`. A mismatch pulses `hdr_err_o` and drops that packet's payload.
- Not defined: the header word is discarded unchecked, `hdr_err_o` is tied 0, and `drop` logic is removed.

## Structure
- Shared package `fx2_pkg`:
  - FSM state enum (IDLE, OE, RD, GAP).
  - `FX2_EP2_ADR` = 2'b00.
  - Default `HDR_WORD`.
- One sub-module: `fx2_sample_fifo`, a synchronous FIFO with 24-bit width, parameterised depth, and a free-count output.

## Test plan
- Reset: hold `rst_n`=0 while toggling `flag_a` → `slrd`=`sloe`=1, `m_valid_o`=0 throughout.
- One packet:
  - Stimulus: header 16'hA55A, then words 16'h3322, 16'h5544, 16'h6655, remainder of the packet as an incrementing pattern.
  - Required: first samples 24'h443322 and 24'h665555; 170 samples per packet; `slrd` low exactly 256 cycles per packet.
- Backpressure: `m_ready_i`=0 for 50 cycles mid-packet → at most `FIFO_DEPTH` samples buffered, `slrd` stays high once `room`=0, no sample lost or duplicated after release.
- Empty flag: `flag_a` drops after the 10th word → reads stop, `sloe` returns to 1; resume on flag high → sample stream continues without a phase error.
- Header mismatch (macro on): header 16'h1234 → one `hdr_err_o` pulse, zero samples from that packet, next good packet emitted intact.
- Resync: pulse `resync` at ph1 mid-packet → FIFO empties, next word read treated as a header, following samples correctly aligned.

Source files
------------

// File: rtl/fx2_pkg.sv
// fx2_pkg: shared FX2 GPIF read-path types and constants.
package fx2_pkg;

    typedef enum logic [1:0] {IDLE, OE, RD, GAP} rd_state_t;

    localparam logic [1:0]  FX2_EP2_ADR  = 2'b00;
    localparam logic [15:0] FX2_HDR_WORD = 16'hA55A;

endpackage

// File: rtl/fx2_sample_fifo.sv
// fx2_sample_fifo: synchronous sample FIFO with free-entry count; push accepted when full if a pop happens the same cycle.
module fx2_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   free
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp, cnt;
    logic         do_push, do_pop;

    assign cnt     = wp - rp;
    assign valid   = cnt != '0;
    assign free    = FULL - cnt;
    assign do_pop  = pop && valid;
    assign do_push = push && (cnt != FULL || do_pop);
    // Output forced to zero while empty so the idle bus is clean.
    assign dout    = valid ? mem[rp[AW-1:0]] : '0;

    always_ff @(posedge clk)
        if (do_push) mem[wp[AW-1:0]] <= din;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else if (clr) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + (AW+1)'(do_push);
            rp <= rp + (AW+1)'(do_pop);
        end

endmodule

// File: rtl/fx2_stream_reader.sv
// fx2_stream_reader: drains FX2 EP2 OUT over GPIF, strips packet headers and unpacks word triplets into 24-bit samples.
// Header checking is built only when FX2_RD_HDR_CHECK_EN is defined.
module fx2_stream_reader
    import fx2_pkg::*;
#(
    parameter int          PKT_WORDS  = 256,
    parameter logic [15:0] HDR_WORD   = FX2_HDR_WORD,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        resync,
    input  logic        flag_a,
    input  logic [15:0] fd_i,
    output logic        slrd,
    output logic        sloe,
    output logic [1:0]  fifoadr,
    output logic [23:0] m_data_o,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic        hdr_err_o
);
    localparam int WW = $clog2(PKT_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [WW-1:0] LAST = WW'(PKT_WORDS - 1);

    rd_state_t     state, nstate;
    logic          gap_cnt, flag_q, word_v, room, hdr, push, drop;
    logic [15:0]   fd_q, w_prev;
    logic [WW-1:0] wcnt;
    logic [1:0]    ph;
    logic [23:0]   push_data;
    logic [FW-1:0] free;

    assign fifoadr   = FX2_EP2_ADR;
    assign room      = free >= FW'(2);
    assign hdr       = word_v && wcnt == '0;
    assign push      = word_v && !hdr && ph != 2'd0 && !drop && !resync;
    // The previous word is always the earlier half of the current triplet pair.
    assign push_data = (ph == 2'd1) ? {fd_q[7:0], w_prev} : {fd_q, w_prev[15:8]};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            flag_q  <= 1'b0;
            fd_q    <= '0;
            word_v  <= 1'b0;
            state   <= IDLE;
            gap_cnt <= 1'b0;
        end else begin
            flag_q  <= flag_a;
            fd_q    <= fd_i;
            word_v  <= state == RD && !resync;
            state   <= resync ? IDLE : nstate;
            gap_cnt <= !resync && state == GAP && !gap_cnt;
        end

    // GAP spans two cycles so the registered flag reflects the last strobe before the next decision.
    always_comb begin
        nstate = state;
        sloe   = 1'b0;
        slrd   = 1'b1;
        case (state)
            IDLE: begin
                sloe = 1'b1;
                if (flag_q && room) nstate = OE;
            end
            OE:  nstate = RD;
            RD: begin
                slrd   = 1'b0;
                nstate = GAP;
            end
            GAP:     if (gap_cnt) nstate = (flag_q && room) ? RD : IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wcnt   <= '0;
            ph     <= 2'd0;
            w_prev <= '0;
        end else if (resync) begin
            wcnt <= '0;
            ph   <= 2'd0;
        end else if (word_v) begin
            wcnt   <= (wcnt == LAST) ? '0 : wcnt + WW'(1);
            ph     <= (hdr || ph == 2'd2) ? 2'd0 : ph + 2'd1;
            w_prev <= fd_q;
        end

`ifdef FX2_RD_HDR_CHECK_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            drop      <= 1'b0;
            hdr_err_o <= 1'b0;
        end else if (resync) begin
            drop      <= 1'b0;
            hdr_err_o <= 1'b0;
        end else begin
            drop      <= hdr ? fd_q != HDR_WORD : drop;
            hdr_err_o <= hdr && fd_q != HDR_WORD;
        end
`else
    assign drop      = 1'b0;
    assign hdr_err_o = 1'b0;
`endif

    fx2_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (24)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (resync),
        .push  (push),
        .din   (push_data),
        .pop   (m_ready_i),
        .dout  (m_data_o),
        .valid (m_valid_o),
        .free  (free)
    );

endmodule
